vga_timing_gen: RTL

Generates the VGA raster timing for the game display from the 100 MHz board clock. It divides the clock down to a pixel-enable strobe and runs the horizontal and vertical pixel counters. From those counters it drives the sync pulses, the active-video flag, a one-clock frame tick and a one-clock seconds tick. It sits directly upstream of the slug generator and the other sprite and background generators, which consume Hcount, Vcount, frame and sec.

---
 rtl/vga_timing_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (pixel strobe, H/V counters, syncs, frame and seconds ticks).
// Define GAME_PAUSE_EN to add a pause input that suppresses and freezes the frame/sec ticks.
module vga_timing_gen #(
    parameter int CLK_DIV        = 4,
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       reset,
`ifdef GAME_PAUSE_EN
    input  logic       pause,
`endif
    output logic       pix_en,
    output logic [9:0] Hcount,
    output logic [9:0] Vcount,
    output logic       Hsync,
    output logic       Vsync,
    output logic       active,
    output logic       frame,
    output logic       sec
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int FW = FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] F_LAST   = FW'(FRAMES_PER_SEC - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);

    logic [DW-1:0] div_q, div_d;
    logic [FW-1:0] fc_q, fc_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic          pix_q, pix_d, hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic          frame_q, frame_d, sec_q, sec_d;
    logic          h_wrap, v_wrap, tick, hold;

`ifdef GAME_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Syncs and active decode the next counter values so they register in step with the counters.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_d   = (div_q == DIV_LAST);
        h_wrap  = pix_q && (h_q == H_LAST);
        v_wrap  = h_wrap && (v_q == V_LAST);
        h_d     = h_wrap ? '0 : h_q + {9'd0, pix_q};
        v_d     = v_wrap ? '0 : v_q + {9'd0, h_wrap};
        hs_d    = !((h_d >= HS_START) && (h_d <= HS_END));
        vs_d    = !((v_d >= VS_START) && (v_d <= VS_END));
        act_d   = (h_d < H_ACT) && (v_d < V_ACT);
        tick    = v_wrap && !hold;
        fc_d    = tick ? ((fc_q == F_LAST) ? '0 : fc_q + 1'b1) : fc_q;
        frame_d = tick;
        sec_d   = tick && (fc_q == F_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q   <= '0;
            fc_q    <= '0;
            h_q     <= '0;
            v_q     <= '0;
            pix_q   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            act_q   <= 1'b1;
            frame_q <= 1'b0;
            sec_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            fc_q    <= fc_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pix_q   <= pix_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            act_q   <= act_d;
            frame_q <= frame_d;
            sec_q   <= sec_d;
        end
    end

    assign pix_en = pix_q;
    assign Hcount = h_q;
    assign Vcount = v_q;
    assign Hsync  = hs_q;
    assign Vsync  = vs_q;
    assign active = act_q;
    assign frame  = frame_q;
    assign sec    = sec_q;
endmodule
